sram_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the SRAM controller. Port 0 is the MEM-stage data path; port 1 is the instruction fetch / cache refill path.
- Latches one requester's command, drives mem_read/mem_write/address/data to the controller and holds them until the controller's ready.
- Returns read data plus a one-cycle ack to the winner, then forces a one-cycle command-idle gap so the controller's internal counter returns to 0.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/sram_arbiter_rr_arb2.sv | 29 ++
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, default widths, port ids.
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF  = 18;
    localparam int WDATA_W_DEF = 32;
    localparam int RDATA_W_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Combinational two-way arbiter: one-hot grant from two requests and the last-granted port.
// Zero latency; ties go to the port not granted last, or always to port 0 when FIXED_PRIO != 0.
import sram_arbiter_pkg::*;

module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            if ((FIXED_PRIO != 0) || (i_last_grant == PORT1)) begin
                o_grant = 2'b01;
            end else begin
                o_grant = 2'b10;
            end
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port sequencer in front of the SRAM controller: latch a winner, hold the command until mem_ready, ack, then one idle gap.
// Command visible the cycle after grant; ack visible the cycle after mem_ready is sampled; requests wait while busy.
import sram_arbiter_pkg::*;

module sram_arbiter #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WDATA_W    = WDATA_W_DEF,
    parameter int RDATA_W    = RDATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               we0,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [WDATA_W-1:0] wdata0,
    output logic               ack0,
    input  logic               req1,
    input  logic               we1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata1,
    output logic               ack1,
    output logic [RDATA_W-1:0] rdata,
    output logic               busy,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDATA_W-1:0] mem_rdata,
    input  logic               mem_ready
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic                 r_win;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_busy;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [WDATA_W-1:0]   r_mem_wdata;
    logic [RDATA_W-1:0]   r_rdata;
    logic [1:0]           w_grant;
    logic                 w_sel;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [WDATA_W-1:0]   w_sel_wdata;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last),
        .o_grant      (w_grant)
    );

    assign w_sel       = w_grant[1];
    assign w_sel_we    = w_sel ? we1    : we0;
    assign w_sel_addr  = w_sel ? addr1  : addr0;
    assign w_sel_wdata = w_sel ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // mem_ready outside BUSY is deliberately ignored; GAP never grants.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_grant) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_ready) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= PORT1;
            r_win       <= PORT0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        r_win       <= w_sel;
                        r_last      <= w_sel;
                        r_mem_write <= w_sel_we;
                        r_mem_read  <= !w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_mem_read) r_rdata <= mem_rdata;
                        r_ack0 <= (r_win == PORT0);
                        r_ack1 <= (r_win == PORT1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin instance and a fixed-priority instance share request inputs,
// each with its own stub controller; completed transactions are scored against an expected queue.
module tb_sram_arbiter;

    localparam int STUB_LAT = 6;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [17:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [63:0] rd_val = '0;
    logic        spur = 1'b0;

    logic        a_ack0, a_ack1, a_busy, a_mr, a_mw, a_rdy, a_stub_rdy;
    logic [63:0] a_rdata;
    logic [17:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_ack0, b_ack1, b_busy, b_mr, b_mw, b_rdy, b_stub_rdy;
    logic [63:0] b_rdata;
    logic [17:0] b_addr;
    logic [31:0] b_wdata;
    int          a_cnt, b_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic [63:0] last_rd = '0;

    always #5 clk = ~clk;

    assign a_rdy = a_stub_rdy | spur;
    assign b_rdy = b_stub_rdy | spur;

    sram_arbiter #(.FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(a_ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(a_ack1),
        .rdata(a_rdata), .busy(a_busy), .mem_read(a_mr), .mem_write(a_mw),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(rd_val), .mem_ready(a_rdy)
    );

    sram_arbiter #(.FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(b_ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(b_ack1),
        .rdata(b_rdata), .busy(b_busy), .mem_read(b_mr), .mem_write(b_mw),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(rd_val), .mem_ready(b_rdy)
    );

    // Stub controllers: ready for one cycle after the command has been held STUB_LAT cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt <= 0; a_stub_rdy <= 1'b0;
        end else if ((a_mr | a_mw) && !a_stub_rdy) begin
            if (a_cnt == STUB_LAT - 1) a_stub_rdy <= 1'b1;
            else a_cnt <= a_cnt + 1;
        end else begin
            a_cnt <= 0; a_stub_rdy <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt <= 0; b_stub_rdy <= 1'b0;
        end else if ((b_mr | b_mw) && !b_stub_rdy) begin
            if (b_cnt == STUB_LAT - 1) b_stub_rdy <= 1'b1;
            else b_cnt <= b_cnt + 1;
        end else begin
            b_cnt <= 0; b_stub_rdy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
    endtask

    task automatic push(input logic port, input logic we, input logic [17:0] addr,
                        input logic [31:0] wdata);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
        if (!we) last_rd = rd_val;
        e.rdata = last_rd;
        sb.push_back(e);
    endtask

    // Run one transaction on the round-robin instance and score it against the queue head.
    task automatic txn_a(input bit drop_req);
        exp_t        e;
        bit          seen = 1'b0, got = 1'b0;
        logic        port = 1'b0, cw = 1'b0;
        logic [17:0] caddr = '0;
        logic [31:0] cwd = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (a_mr && a_mw) chk("cmd_exclusive", {a_mr, a_mw}, 2'b00);
            if (!seen && (a_mr || a_mw)) begin
                seen = 1'b1; caddr = a_addr; cw = a_mw; cwd = a_wdata;
                if (drop_req) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (a_ack0 || a_ack1) begin
                got = 1'b1;
                port = a_ack1;
                chk("ack_both", {a_ack0, a_ack1} == 2'b11, 1'b0);
                chk("gap_cmd_idle", {a_mr, a_mw}, 2'b00);
                chk("gap_busy", a_busy, 1'b1);
            end
        end
        if (!got || sb.size() == 0) begin
            chk("ack_timeout", got, 1'b0 == 1'b1);
        end else begin
            e = sb.pop_front();
            chk("grant_port", port, e.port);
            chk("cmd_addr", caddr, e.addr);
            chk("cmd_write", cw, e.we);
            chk("cmd_wdata", cwd, e.wdata);
            chk("rdata", a_rdata, e.rdata);
            @(negedge clk);
            chk("ack_one_cycle", {a_ack0, a_ack1}, 2'b00);
            chk("busy_cleared", a_busy, 1'b0);
        end
    endtask

    initial begin
        int n0, n1;
        bit hit;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", {a_ack0, a_ack1, b_ack0, b_ack1}, 4'b0);
        chk("rst_cmd", {a_mr, a_mw, a_busy}, 3'b0);
        chk("rst_addr", a_addr, 18'h0);
        chk("rst_wdata", a_wdata, 32'h0);
        chk("rst_rdata", a_rdata, 64'h0);
        rst_n = 1'b1;

        // 1: single read on port 0
        rd_val = 64'h1111_2222_3333_4444;
        we0 = 1'b0; addr0 = 18'h00100; wdata0 = 32'h0; req0 = 1'b1;
        push(1'b0, 1'b0, 18'h00100, 32'h0);
        txn_a(1'b1);

        // 2: both requesting continuously from reset -> 0,1,0,1
        do_reset();
        rd_val = 64'h5555_6666_7777_8888;
        addr0 = 18'h00011; wdata0 = 32'h0000_0A0A; we0 = 1'b0;
        addr1 = 18'h00022; wdata1 = 32'h0000_0B0B; we1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(1'b0, 1'b0, 18'h00011, 32'h0000_0A0A);
            else            push(1'b1, 1'b0, 18'h00022, 32'h0000_0B0B);
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) txn_a(1'b0);
        req0 = 1'b0; req1 = 1'b0;

        // 4: write then read on port 1, same address
        repeat (2) @(negedge clk);
        rd_val = 64'hAAAA_BBBB_CCCC_DDDD;
        we1 = 1'b1; addr1 = 18'h0002A; wdata1 = 32'hDEAD_BEEF; req1 = 1'b1;
        push(1'b1, 1'b1, 18'h0002A, 32'hDEAD_BEEF);
        txn_a(1'b1);
        we1 = 1'b0; req1 = 1'b1;
        push(1'b1, 1'b0, 18'h0002A, 32'hDEAD_BEEF);
        txn_a(1'b1);

        // 6: spurious mem_ready in IDLE, then early request drop
        spur = 1'b1;
        hit = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack0 || a_ack1 || a_busy) hit = 1'b1;
        end
        spur = 1'b0;
        @(negedge clk);
        if (a_ack0 || a_ack1 || a_busy) hit = 1'b1;
        chk("spurious_ready", hit, 1'b0);
        rd_val = 64'h0123_4567_89AB_CDEF;
        we0 = 1'b0; addr0 = 18'h3FFFF; wdata0 = 32'h1234_5678; req0 = 1'b1;
        push(1'b0, 1'b0, 18'h3FFFF, 32'h1234_5678);
        txn_a(1'b1);

        // 3: fixed priority instance
        do_reset();
        we0 = 1'b0; we1 = 1'b0; req0 = 1'b1; req1 = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 200 && n0 < 3; i++) begin
            @(negedge clk);
            if (b_ack0) n0++;
            if (b_ack1) n1++;
        end
        req0 = 1'b0;
        chk("fixed_p0_wins", n0, 3);
        chk("fixed_p1_starved", n1, 0);
        for (int i = 0; i < 60 && n1 == 0; i++) begin
            @(negedge clk);
            if (b_ack0) n0++;
            if (b_ack1) n1++;
        end
        req1 = 1'b0;
        chk("fixed_p1_after_drop", n1, 1);
        chk("fixed_no_extra_p0", n0, 3);

        // 5: reset in the middle of a port 0 read
        do_reset();
        sb.delete();
        addr0 = 18'h00077; wdata0 = 32'h0; we0 = 1'b0; req0 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = a_mr;
        end
        chk("mid_cmd_started", hit, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async", {a_ack0, a_ack1, a_busy, a_mr, a_mw}, 5'b0);
        chk("mid_rst_addr", a_addr, 18'h0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00099;
        @(negedge clk);
        chk("mid_rst_no_ack", {a_ack0, a_ack1}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        rd_val = 64'hFEED_FACE_CAFE_F00D;
        push(1'b0, 1'b0, 18'h00077, 32'h0);
        txn_a(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
